rf_mp: RTL and testbench
========================

# rf_mp

Parametrised multi-port integer register file with a built-in busy scoreboard. It is the next-generation replacement for the core's 2R1W register file and serves dual-issue and out-of-order-writeback pipelines. It provides NRD combinational read ports, NWR synchronous write ports with fixed priority, optional write-to-read bypass, and per-register busy tracking so the issue stage can detect RAW hazards without a separate scoreboard block.

## Interface
Parameters:
- XLEN, 32, data width of each register.
- NREGS, 32, number of architectural registers (power of two, ≥ 2); AW = $clog2(NREGS).
- NRD, 2, number of read ports (≥ 1).
- NWR, 2, number of write ports (≥ 1).
- ZERO_REG, 1, when 1, register 0 reads as 0, ignores writes and is never busy.
- BYPASS, 1, when 1, same-cycle write data is forwarded to reads.

Ports:
- clk  input  1  core clock; all state updates on its rising edge.
- rst_n  input  1  asynchronous, active-low reset.
- raddr  input  NRD×AW  read addresses.
- rdata  output  NRD×XLEN  read data.
- rbusy  output  NRD  busy flag of the addressed register.
- we  input  NWR  write enables.
- waddr  input  NWR×AW  write addresses.
- wdata  input  NWR×XLEN  write data.
- alloc_en  input  1  marks alloc_addr busy (a new producer has been issued).
- alloc_addr  input  AW  register to mark busy.
- busy_vec  output  NREGS  current busy bit of every register.

## Operation
- Storage: NREGS × XLEN flops and an NREGS-bit busy vector; no memory macro.
- Write: on a clock edge, for each register r, if any port p has we[p] and waddr[p]==r, then mem[r] <= wdata of the highest-indexed such port. Lower-indexed ports lose conflicts silently.
- ZERO_REG=1: writes to r=0 are dropped; rdata reads 0 for address 0; busy[0] is held at 0.
- Read: rdata[i] = mem[raddr[i]], combinational.
  - BYPASS=1: if some port writes raddr[i] this cycle (and the address is not register 0 under ZERO_REG), rdata[i] is that port's wdata, using the same highest-index priority.
  - BYPASS=0: rdata shows the old value until the edge.
- Scoreboard, per register r at the clock edge:
  - If alloc_en and alloc_addr==r, busy[r] <= 1. Allocation wins over a same-cycle write, because it belongs to the newer producer.
  - Otherwise, if any write port writes r, busy[r] <= 0.
  - Otherwise, busy[r] holds.
- rbusy[i] = busy[raddr[i]], the registered value only (not bypassed). busy_vec = busy.
- Out-of-range addresses cannot occur because NREGS is a power of two.

## Timing
- Reset (rst_n low, asynchronous): all mem entries = 0 and all busy bits = 0. Consequently every rdata = 0, every rbusy = 0 and busy_vec = 0 while in reset.
- Read latency: 0 cycles (combinational from raddr/state).
- Write latency: the value is visible on the first edge after we is asserted, or in the same cycle when BYPASS=1.
- Busy latency: busy is set on the edge after alloc_en and cleared on the edge after the write.
- Reset asserted mid-cycle: any pending write and alloc are discarded. Deassertion is synchronised externally; the first edge after release performs normal writes.
- There is no handshake; writes and allocs are always accepted.

## Test plan
- Reset with XLEN=32, NREGS=32, NRD=2, NWR=2: preload r5 = 0x1234 via port 0, then pulse rst_n low mid-cycle -> r5 reads 0 immediately, busy_vec = 0.
- Write conflict: port0 writes r7 = 0xAAAA_AAAA and port1 writes r7 = 0x5555_5555 in the same cycle -> after the edge, rdata for r7 = 0x5555_5555. With BYPASS=1 the same value also appears in that cycle.
- Bypass: BYPASS=1, write r3 = 0xDEAD_BEEF while raddr[0]=3 -> rdata[0] = 0xDEAD_BEEF in the same cycle. With BYPASS=0 the old value appears that cycle and the new value the next.
- Zero register: ZERO_REG=1, write r0 = 0xFFFF_FFFF with alloc_en on r0 -> rdata = 0 and busy_vec[0] = 0 throughout.
- Scoreboard: alloc r9 -> rbusy for r9 = 1 next cycle. Then write r9 together with alloc r9 in one cycle -> r9 stays busy and holds the new data. Then write r9 alone -> busy clears after the edge.
- Parameter sweep: NREGS=16, NRD=3, NWR=1, XLEN=64 -> random write/read/alloc traffic matches the reference model across all ports.

Source files
------------

// File: rtl/rf_mp.sv
// rf_mp: multi-port integer register file with an integrated busy scoreboard.
// NRD combinational read ports and NWR synchronous write ports are provided.
// When several ports write the same register, the highest-indexed port wins.
// Optional same-cycle write-to-read bypass is selected with BYPASS.
// Register 0 can be hard-wired to zero with ZERO_REG.
// Busy bits track outstanding producers: alloc sets a bit and a write clears it.
// A same-cycle alloc takes priority over a write to the same register.
module rf_mp #(
    parameter int XLEN     = 32,
    parameter int NREGS    = 32,
    parameter int NRD      = 2,
    parameter int NWR      = 2,
    parameter bit ZERO_REG = 1'b1,
    parameter bit BYPASS   = 1'b1,
    localparam int AW      = $clog2(NREGS)
) (
    input  logic                      clk,
    input  logic                      rst_n,
    input  logic [NRD-1:0][AW-1:0]    raddr,
    output logic [NRD-1:0][XLEN-1:0]  rdata,
    output logic [NRD-1:0]            rbusy,
    input  logic [NWR-1:0]            we,
    input  logic [NWR-1:0][AW-1:0]    waddr,
    input  logic [NWR-1:0][XLEN-1:0]  wdata,
    input  logic                      alloc_en,
    input  logic [AW-1:0]             alloc_addr,
    output logic [NREGS-1:0]          busy_vec
);

    logic [XLEN-1:0]  mem_r [NREGS];
    logic [NREGS-1:0] busy_r;

    logic [NREGS-1:0] wr_hit_s;
    logic [XLEN-1:0]  wr_data_s [NREGS];
    logic [NREGS-1:0] busy_nxt_s;

    // Per-register write decode: later (higher-indexed) ports override earlier ones
    always_comb begin
        for (int r = 0; r < NREGS; r++) begin
            wr_hit_s[r]  = 1'b0;
            wr_data_s[r] = '0;
            for (int p = 0; p < NWR; p++) begin
                wr_hit_s[r]  = wr_hit_s[r] | (we[p] & (waddr[p] == AW'(r)));
                wr_data_s[r] = (we[p] && (waddr[p] == AW'(r))) ? wdata[p] : wr_data_s[r];
            end
        end
        // register 0 is read-only when hard-wired to zero
        wr_hit_s[0] = ZERO_REG ? 1'b0 : wr_hit_s[0];
    end

    // Next busy state: alloc (newer producer) beats a write, which beats hold
    always_comb begin
        for (int r = 0; r < NREGS; r++) begin
            busy_nxt_s[r] = (alloc_en && (alloc_addr == AW'(r))) ? 1'b1 :
                            (wr_hit_s[r] ? 1'b0 : busy_r[r]);
        end
        busy_nxt_s[0] = ZERO_REG ? 1'b0 : busy_nxt_s[0];
    end

    // Storage and busy-vector update; reset discards any pending write/alloc
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int r = 0; r < NREGS; r++) begin
                mem_r[r] <= '0;
            end
            busy_r <= '0;
        end else begin
            for (int r = 0; r < NREGS; r++) begin
                mem_r[r] <= wr_hit_s[r] ? wr_data_s[r] : mem_r[r];
            end
            busy_r <= busy_nxt_s;
        end
    end

    // Combinational read ports with optional same-cycle forwarding of write data
    always_comb begin
        for (int i = 0; i < NRD; i++) begin
            rdata[i] = mem_r[raddr[i]];
            rdata[i] = (BYPASS && wr_hit_s[raddr[i]]) ? wr_data_s[raddr[i]] : rdata[i];
            rdata[i] = (ZERO_REG && (raddr[i] == '0)) ? '0 : rdata[i];
            // busy is reported from the registered state only, never forwarded
            rbusy[i] = busy_r[raddr[i]];
        end
    end

    assign busy_vec = busy_r;

endmodule

// File: tb/tb_rf_mp.sv
// Self-checking bench for rf_mp: default config (bypass on), a bypass-off copy,
// and a swept config (NREGS=16, NRD=3, NWR=1, XLEN=64) run against a reference model.
module tb_rf_mp;

    logic clk = 1'b0;
    logic rst_n;
    always #5 clk = ~clk;

    // default-config stimulus shared by DUT A (BYPASS=1) and DUT B (BYPASS=0)
    logic [1:0][4:0]  raddr;
    logic [1:0]       we;
    logic [1:0][4:0]  waddr;
    logic [1:0][31:0] wdata;
    logic             alloc_en;
    logic [4:0]       alloc_addr;
    logic [1:0][31:0] rdata_a, rdata_b;
    logic [1:0]       rbusy_a, rbusy_b;
    logic [31:0]      bv_a, bv_b;

    // swept-config stimulus
    logic [2:0][3:0]  raddr_c;
    logic [0:0]       we_c;
    logic [0:0][3:0]  waddr_c;
    logic [0:0][63:0] wdata_c;
    logic             alloc_en_c;
    logic [3:0]       alloc_addr_c;
    logic [2:0][63:0] rdata_c;
    logic [2:0]       rbusy_c;
    logic [15:0]      bv_c;

    rf_mp u_a (
        .clk(clk), .rst_n(rst_n), .raddr(raddr), .rdata(rdata_a), .rbusy(rbusy_a),
        .we(we), .waddr(waddr), .wdata(wdata), .alloc_en(alloc_en),
        .alloc_addr(alloc_addr), .busy_vec(bv_a)
    );

    rf_mp #(.BYPASS(1'b0)) u_b (
        .clk(clk), .rst_n(rst_n), .raddr(raddr), .rdata(rdata_b), .rbusy(rbusy_b),
        .we(we), .waddr(waddr), .wdata(wdata), .alloc_en(alloc_en),
        .alloc_addr(alloc_addr), .busy_vec(bv_b)
    );

    rf_mp #(.XLEN(64), .NREGS(16), .NRD(3), .NWR(1)) u_c (
        .clk(clk), .rst_n(rst_n), .raddr(raddr_c), .rdata(rdata_c), .rbusy(rbusy_c),
        .we(we_c), .waddr(waddr_c), .wdata(wdata_c), .alloc_en(alloc_en_c),
        .alloc_addr(alloc_addr_c), .busy_vec(bv_c)
    );

    int n_checks = 0;
    int n_pass   = 0;
    logic [63:0] exp_q [$];
    logic [63:0] e;

    // reference model for the swept configuration
    logic [63:0] mem_m [16];
    logic [15:0] busy_m;

    task automatic idle();
        we = 2'b00; waddr = '0; wdata = '0; alloc_en = 1'b0; alloc_addr = 5'd0;
    endtask

    task automatic test_reset();
        rst_n = 1'b0; idle(); raddr[0] = 5'd5; raddr[1] = 5'd0;
        we_c = 1'b0; waddr_c = '0; wdata_c = '0; alloc_en_c = 1'b0; alloc_addr_c = 4'd0; raddr_c = '0;
        #2;
        exp_q.push_back(64'd0); exp_q.push_back(64'd0);
        e = exp_q.pop_front(); n_checks++;
        if (rdata_a[0] !== e[31:0]) $display("FAIL reset_rdata got %h expected %h", rdata_a[0], e[31:0]); else n_pass++;
        e = exp_q.pop_front(); n_checks++;
        if (bv_a !== e[31:0]) $display("FAIL reset_busy got %h expected %h", bv_a, e[31:0]); else n_pass++;
        // release, then preload r5 via port 0
        @(negedge clk); rst_n = 1'b1;
        we = 2'b01; waddr[0] = 5'd5; wdata[0] = 32'h0000_1234;
        exp_q.push_back(64'h1234);
        @(posedge clk); #1;
        e = exp_q.pop_front(); n_checks++;
        if (rdata_b[0] !== e[31:0]) $display("FAIL preload_r5 got %h expected %h", rdata_b[0], e[31:0]); else n_pass++;
        // mid-cycle reset with a pending write and alloc
        @(negedge clk); idle();
        #2; rst_n = 1'b0; we = 2'b01; wdata[0] = 32'hFFFF_0000; waddr[0] = 5'd5;
        alloc_en = 1'b1; alloc_addr = 5'd5;
        exp_q.push_back(64'd0); exp_q.push_back(64'd0);
        #1;
        e = exp_q.pop_front(); n_checks++;
        if (rdata_b[0] !== e[31:0]) $display("FAIL midreset_rdata got %h expected %h", rdata_b[0], e[31:0]); else n_pass++;
        e = exp_q.pop_front(); n_checks++;
        if (bv_a !== e[31:0]) $display("FAIL midreset_busy got %h expected %h", bv_a, e[31:0]); else n_pass++;
        @(posedge clk); #1;
        exp_q.push_back(64'd0);
        e = exp_q.pop_front(); n_checks++;
        if (bv_a !== e[31:0]) $display("FAIL inreset_busy got %h expected %h", bv_a, e[31:0]); else n_pass++;
        @(negedge clk); idle(); rst_n = 1'b1;
        @(posedge clk); #1;
        exp_q.push_back(64'd0);
        e = exp_q.pop_front(); n_checks++;
        if (rdata_a[0] !== e[31:0]) $display("FAIL postreset_r5 got %h expected %h", rdata_a[0], e[31:0]); else n_pass++;
    endtask

    task automatic test_conflict();
        @(negedge clk); idle();
        we = 2'b11; waddr[0] = 5'd7; waddr[1] = 5'd7;
        wdata[0] = 32'hAAAA_AAAA; wdata[1] = 32'h5555_5555; raddr[0] = 5'd7;
        exp_q.push_back(64'h5555_5555); exp_q.push_back(64'd0);
        #1;
        e = exp_q.pop_front(); n_checks++;
        if (rdata_a[0] !== e[31:0]) $display("FAIL conflict_bypass got %h expected %h", rdata_a[0], e[31:0]); else n_pass++;
        e = exp_q.pop_front(); n_checks++;
        if (rdata_b[0] !== e[31:0]) $display("FAIL conflict_nobypass_old got %h expected %h", rdata_b[0], e[31:0]); else n_pass++;
        @(posedge clk); #1;
        @(negedge clk); idle();
        exp_q.push_back(64'h5555_5555); exp_q.push_back(64'h5555_5555);
        #1;
        e = exp_q.pop_front(); n_checks++;
        if (rdata_a[0] !== e[31:0]) $display("FAIL conflict_a_after got %h expected %h", rdata_a[0], e[31:0]); else n_pass++;
        e = exp_q.pop_front(); n_checks++;
        if (rdata_b[0] !== e[31:0]) $display("FAIL conflict_b_after got %h expected %h", rdata_b[0], e[31:0]); else n_pass++;
    endtask

    task automatic test_bypass();
        @(negedge clk); idle();
        we = 2'b01; waddr[0] = 5'd3; wdata[0] = 32'hDEAD_BEEF; raddr[0] = 5'd3; raddr[1] = 5'd7;
        exp_q.push_back(64'hDEAD_BEEF); exp_q.push_back(64'd0); exp_q.push_back(64'h5555_5555);
        #1;
        e = exp_q.pop_front(); n_checks++;
        if (rdata_a[0] !== e[31:0]) $display("FAIL bypass_same_cycle got %h expected %h", rdata_a[0], e[31:0]); else n_pass++;
        e = exp_q.pop_front(); n_checks++;
        if (rdata_b[0] !== e[31:0]) $display("FAIL nobypass_old got %h expected %h", rdata_b[0], e[31:0]); else n_pass++;
        e = exp_q.pop_front(); n_checks++;
        if (rdata_a[1] !== e[31:0]) $display("FAIL bypass_other_port got %h expected %h", rdata_a[1], e[31:0]); else n_pass++;
        @(negedge clk); idle();
        exp_q.push_back(64'hDEAD_BEEF);
        #1;
        e = exp_q.pop_front(); n_checks++;
        if (rdata_b[0] !== e[31:0]) $display("FAIL nobypass_next got %h expected %h", rdata_b[0], e[31:0]); else n_pass++;
    endtask

    task automatic test_zero();
        @(negedge clk); idle();
        we = 2'b11; waddr[0] = 5'd0; waddr[1] = 5'd0;
        wdata[0] = 32'hFFFF_FFFF; wdata[1] = 32'hFFFF_FFFF;
        alloc_en = 1'b1; alloc_addr = 5'd0; raddr[0] = 5'd0; raddr[1] = 5'd0;
        exp_q.push_back(64'd0); exp_q.push_back(64'd0);
        #1;
        e = exp_q.pop_front(); n_checks++;
        if (rdata_a[0] !== e[31:0]) $display("FAIL zero_bypass got %h expected %h", rdata_a[0], e[31:0]); else n_pass++;
        e = exp_q.pop_front(); n_checks++;
        if (bv_a[0] !== e[0]) $display("FAIL zero_busy_now got %b expected %b", bv_a[0], e[0]); else n_pass++;
        @(negedge clk); idle(); raddr[0] = 5'd0;
        exp_q.push_back(64'd0); exp_q.push_back(64'd0); exp_q.push_back(64'd0);
        #1;
        e = exp_q.pop_front(); n_checks++;
        if (rdata_b[0] !== e[31:0]) $display("FAIL zero_after got %h expected %h", rdata_b[0], e[31:0]); else n_pass++;
        e = exp_q.pop_front(); n_checks++;
        if (bv_a[0] !== e[0]) $display("FAIL zero_busy_after got %b expected %b", bv_a[0], e[0]); else n_pass++;
        e = exp_q.pop_front(); n_checks++;
        if (rbusy_a[0] !== e[0]) $display("FAIL zero_rbusy got %b expected %b", rbusy_a[0], e[0]); else n_pass++;
    endtask

    task automatic test_scoreboard();
        @(negedge clk); idle();
        alloc_en = 1'b1; alloc_addr = 5'd9; raddr[1] = 5'd9;
        exp_q.push_back(64'd0);
        #1;
        e = exp_q.pop_front(); n_checks++;
        if (rbusy_a[1] !== e[0]) $display("FAIL alloc_same_cycle got %b expected %b", rbusy_a[1], e[0]); else n_pass++;
        // write + alloc together: stays busy, takes the data
        @(negedge clk); idle();
        alloc_en = 1'b1; alloc_addr = 5'd9; we = 2'b10; waddr[1] = 5'd9; wdata[1] = 32'hCAFE_0009;
        exp_q.push_back(64'd1); exp_q.push_back(64'h0000_0200);
        #1;
        e = exp_q.pop_front(); n_checks++;
        if (rbusy_a[1] !== e[0]) $display("FAIL alloc_busy got %b expected %b", rbusy_a[1], e[0]); else n_pass++;
        e = exp_q.pop_front(); n_checks++;
        if (bv_b !== e[31:0]) $display("FAIL alloc_busy_vec got %h expected %h", bv_b, e[31:0]); else n_pass++;
        @(negedge clk); idle();
        we = 2'b01; waddr[0] = 5'd9; wdata[0] = 32'h0000_1111;
        exp_q.push_back(64'd1); exp_q.push_back(64'hCAFE_0009); exp_q.push_back(64'h0000_1111);
        #1;
        e = exp_q.pop_front(); n_checks++;
        if (rbusy_b[1] !== e[0]) $display("FAIL alloc_wins got %b expected %b", rbusy_b[1], e[0]); else n_pass++;
        e = exp_q.pop_front(); n_checks++;
        if (rdata_b[1] !== e[31:0]) $display("FAIL alloc_write_data got %h expected %h", rdata_b[1], e[31:0]); else n_pass++;
        e = exp_q.pop_front(); n_checks++;
        if (rdata_a[1] !== e[31:0]) $display("FAIL write_bypass_r9 got %h expected %h", rdata_a[1], e[31:0]); else n_pass++;
        @(negedge clk); idle();
        exp_q.push_back(64'd0); exp_q.push_back(64'd0); exp_q.push_back(64'h0000_1111);
        #1;
        e = exp_q.pop_front(); n_checks++;
        if (rbusy_a[1] !== e[0]) $display("FAIL write_clears_busy got %b expected %b", rbusy_a[1], e[0]); else n_pass++;
        e = exp_q.pop_front(); n_checks++;
        if (bv_a !== e[31:0]) $display("FAIL busy_vec_clear got %h expected %h", bv_a, e[31:0]); else n_pass++;
        e = exp_q.pop_front(); n_checks++;
        if (rdata_b[1] !== e[31:0]) $display("FAIL write_r9_data got %h expected %h", rdata_b[1], e[31:0]); else n_pass++;
    endtask

    task automatic test_sweep();
        logic [3:0]  ra;
        logic [63:0] ev;
        for (int r = 0; r < 16; r++) mem_m[r] = 64'd0;
        busy_m = 16'd0;
        for (int cyc = 0; cyc < 300; cyc++) begin
            @(negedge clk);
            we_c[0]      = 1'($urandom_range(0, 1));
            waddr_c[0]   = 4'($urandom_range(0, 15));
            wdata_c[0]   = {$urandom, $urandom};
            alloc_en_c   = ($urandom_range(0, 2) == 0);
            alloc_addr_c = 4'($urandom_range(0, 15));
            for (int i = 0; i < 3; i++) raddr_c[i] = 4'($urandom_range(0, 15));
            if (cyc % 3 == 0) raddr_c[0] = waddr_c[0];
            if (cyc % 5 == 0) raddr_c[2] = alloc_addr_c;
            for (int i = 0; i < 3; i++) begin
                ra = raddr_c[i];
                ev = mem_m[ra];
                if (we_c[0] && waddr_c[0] == ra) ev = wdata_c[0];
                if (ra == 4'd0) ev = 64'd0;
                exp_q.push_back(ev);
                exp_q.push_back({63'd0, busy_m[ra]});
            end
            exp_q.push_back({48'd0, busy_m});
            #1;
            for (int i = 0; i < 3; i++) begin
                e = exp_q.pop_front(); n_checks++;
                if (rdata_c[i] !== e) $display("FAIL sweep_rdata port%0d cyc%0d got %h expected %h", i, cyc, rdata_c[i], e); else n_pass++;
                e = exp_q.pop_front(); n_checks++;
                if (rbusy_c[i] !== e[0]) $display("FAIL sweep_rbusy port%0d cyc%0d got %b expected %b", i, cyc, rbusy_c[i], e[0]); else n_pass++;
            end
            e = exp_q.pop_front(); n_checks++;
            if (bv_c !== e[15:0]) $display("FAIL sweep_busy_vec cyc%0d got %h expected %h", cyc, bv_c, e[15:0]); else n_pass++;
            @(posedge clk);
            for (int r = 1; r < 16; r++) begin
                if (alloc_en_c && alloc_addr_c == 4'(r)) busy_m[r] = 1'b1;
                else if (we_c[0] && waddr_c[0] == 4'(r)) busy_m[r] = 1'b0;
            end
            if (we_c[0] && waddr_c[0] != 4'd0) mem_m[waddr_c[0]] = wdata_c[0];
        end
        @(negedge clk);
        we_c = 1'b0; alloc_en_c = 1'b0;
    endtask

    initial begin
        test_reset();
        test_conflict();
        test_bypass();
        test_zero();
        test_scoreboard();
        test_sweep();
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
